// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter and its memory model.
// Pure declarations: no latency, no flow control.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [31:0] DEF_BASE_ADDR   = 32'h1000_0000;
    localparam int unsigned DEF_DEPTH_WORDS = 32;
    localparam int unsigned DEF_WAIT_CYCLES = 2;

    // 33-bit arithmetic so a segment ending at the top of the map cannot wrap.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] depth_words);
        logic [32:0] last;
        last = {1'b0, base} + {depth_words[30:0], 2'b00} - 33'd4;
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} <= last)
               && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester ports, memory strobes and status of the data-memory arbiter.
// slave = arbiter side; master = requesters plus memory.
interface dmem_arbiter_if;

    logic        p0_req,   p1_req;
    logic        p0_we,    p1_we;
    logic [31:0] p0_addr,  p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_done,  p1_done;
    logic        p0_err,   p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    modport slave (
        input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
               p0_wdata, p1_wdata, mem_rdata,
        output p0_done, p1_done, p0_err, p1_err, p0_rdata, p1_rdata,
               mem_read, mem_write, mem_addr, mem_wdata, busy
    );

    modport master (
        output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
               p0_wdata, p1_wdata, mem_rdata,
        input  p0_done, p1_done, p0_err, p1_err, p0_rdata, p1_rdata,
               mem_read, mem_write, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker; grant is combinational, pointer updates on advance_i.
// A tie goes to the port that was not granted last; the pointer resets to 1.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic       gnt_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = 1'b0;
        case (req_i)
            2'b11:   gnt_o = ~ptr_q;
            2'b10:   gnt_o = 1'b1;
            default: gnt_o = 1'b0;
        endcase
        ptr_d = advance_i ? gnt_o : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b1;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and strobe sequencer for the single-port data memory.
// Valid access: done WAIT_CYCLES+1 cycles after grant; range error: done next cycle.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS
) (
    input  logic           clk,
    input  logic           reset_n,
    dmem_arbiter_if.slave  bus
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        port_q;
    logic        we_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [1:0]  done_q;
    logic [1:0]  err_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;
    logic        busy_q;

    logic [1:0]  req;
    logic        gnt;
    logic        advance;
    logic        sel_we;
    logic        sel_ok;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    assign req       = {bus.p1_req, bus.p0_req};
    assign advance   = (state_q == IDLE) && (req != 2'b00);
    assign sel_we    = gnt ? bus.p1_we    : bus.p0_we;
    assign sel_addr  = gnt ? bus.p1_addr  : bus.p0_addr;
    assign sel_wdata = gnt ? bus.p1_wdata : bus.p0_wdata;
    assign sel_ok    = addr_in_range(sel_addr, BASE_ADDR, 32'(DEPTH_WORDS));

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst_n     (reset_n),
        .req_i     (req),
        .advance_i (advance),
        .gnt_o     (gnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            done_q      <= 2'b00;
            err_q       <= 2'b00;
            rdata0_q    <= 32'd0;
            rdata1_q    <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            // Response fields and the write strobe are single-cycle pulses.
            done_q      <= 2'b00;
            err_q       <= 2'b00;
            rdata0_q    <= 32'd0;
            rdata1_q    <= 32'd0;
            mem_write_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req != 2'b00) begin
                        port_q <= gnt;
                        we_q   <= sel_we;
                        busy_q <= 1'b1;
                        if (sel_ok) begin
                            state_q     <= ACCESS;
                            cnt_q       <= CNT_INIT;
                            mem_addr_q  <= sel_addr;
                            mem_wdata_q <= sel_we ? sel_wdata : 32'd0;
                            mem_read_q  <= ~sel_we;
                            mem_write_q <= sel_we && (CNT_INIT == 4'd0);
                        end else begin
                            state_q     <= RESP;
                            done_q[gnt] <= 1'b1;
                            err_q[gnt]  <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        state_q        <= RESP;
                        mem_read_q     <= 1'b0;
                        mem_addr_q     <= 32'd0;
                        mem_wdata_q    <= 32'd0;
                        done_q[port_q] <= 1'b1;
                        if (!we_q) begin
                            if (port_q) rdata1_q <= bus.mem_rdata;
                            else        rdata0_q <= bus.mem_rdata;
                        end
                    end else begin
                        cnt_q       <= cnt_q - 4'd1;
                        // Write strobe lands only in the final ACCESS cycle.
                        mem_write_q <= we_q && (cnt_q == 4'd1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.p0_done   = done_q[0];
    assign bus.p1_done   = done_q[1];
    assign bus.p0_err    = err_q[0];
    assign bus.p1_err    = err_q[1];
    assign bus.p0_rdata  = rdata0_q;
    assign bus.p1_rdata  = rdata1_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer in front of the single-port data memory. Port 0 (CPU load/store unit) and port 1 (DMA/debug loader) issue word requests. The block grants them round-robin, range-checks the address against the data segment, and drives the memory read/write strobes for a fixed number of wait cycles to cover memory latency. It sits between the datapath's memory stage and the data memory.

## Interface
- WAIT_CYCLES, 2, cycles the memory strobes/address are held per access (legal 1..15)
- BASE_ADDR, 32'h1000_0000, first byte address of data segment
- DEPTH_WORDS, 32, words in data segment
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- p0_req / p1_req  in  1  request, held high until matching done
- p0_we / p1_we  in  1  1 = write, 0 = read; stable while req high
- p0_addr / p1_addr  in  32  byte address; stable while req high
- p0_wdata / p1_wdata  in  32  write data; stable while req high
- p0_done / p1_done  out  1  one-cycle completion pulse
- p0_err / p1_err  out  1  valid with done: address out of range or misaligned
- p0_rdata / p1_rdata  out  32  read data, valid with done (0 on write or err)
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_addr  out  32  byte address to memory
- mem_wdata  out  32  write data to memory
- mem_rdata  in  32  read data from memory
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req is high, select a winner and latch its we/addr/wdata and port id.
  - If addr is in range and word aligned, go to ACCESS with wait counter = WAIT_CYCLES-1.
  - Otherwise go to RESP with err=1 and no memory strobe.
- Range: BASE_ADDR <= addr <= BASE_ADDR + 4*DEPTH_WORDS - 4, and addr[1:0]==0. Comparison is unsigned 32-bit.
- Arbitration is round-robin. The last-granted pointer resets to 1, so port 0 wins the first tie. After each grant the pointer = granted port. On a tie, the port not equal to the pointer wins.
- ACCESS: mem_addr = latched addr every cycle.
  - Read: mem_read=1 every ACCESS cycle; mem_rdata is captured at the end of the last cycle (counter==0).
  - Write: mem_wdata = latched data; mem_write=1 only in the last ACCESS cycle, giving exactly one write edge.
  - The counter decrements each cycle; at 0, go to RESP.
- RESP: pulse done for the latched port with err and rdata registered. Always return to IDLE. A request still high in IDLE is re-arbitrated there, so there is no back-to-back grant from RESP.
- If req drops mid-transaction (protocol violation), the transaction still completes and done still pulses.
- Outputs for the non-selected port are 0. Unused mem_* outputs are 0 (mem_addr/mem_wdata 0 in IDLE/RESP).

## Timing
- Reset values: state IDLE, all done/err 0, all rdata 0, mem_read 0, mem_write 0, mem_addr 0, mem_wdata 0, busy 0, pointer 1.
- Reset asserted mid-access: the access aborts at once and mem_write drops asynchronously. A write in flight before its last ACCESS cycle is never issued.
- Latency, req seen in IDLE at cycle T:
  - Valid access: ACCESS spans T+1..T+WAIT_CYCLES, done at T+WAIT_CYCLES+1 (T+3 at default).
  - Error: done at T+1.
- Throughput: one access per WAIT_CYCLES+2 cycles. A waiting port is served within one other transaction.
- All outputs are registered, with no combinational path from req to mem_*.

## Structure
- Package dmem_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - default BASE_ADDR/DEPTH_WORDS constants;
  - an addr_in_range function shared with the memory model.
- Sub-module rr_arb2 contains the two-input round-robin picker and pointer register (inputs req[1:0], advance; output grant id). All sequencing stays in dmem_arbiter.

## Test plan
- Single read: p0 reads 0x1000_0008, mem_rdata=0xDEADBEEF -> mem_read high 2 cycles, p0_done at T+3, p0_rdata=0xDEADBEEF, err=0.
- Single write: p1 writes 0xCAFEF00D to 0x1000_007C -> mem_write high exactly 1 cycle (T+2), mem_addr=0x1000_007C, p1_done at T+3.
- Tie: p0 and p1 both request continuously, 4 transactions -> grant order p0, p1, p0, p1; no port done twice in a row.
- Range errors: p0 reads 0x1000_0080, then 0x1000_0002, then 0x8000_0000 -> each gives done at T+1 with err=1, rdata=0, mem_read/mem_write never asserted.
- Reset mid-write: reset_n low during the first ACCESS cycle of a write -> mem_write never asserts, all outputs 0. After release, a new p1 request is granted first (pointer=1 prefers p0 only on tie).
- WAIT_CYCLES=1 build: back-to-back p0 reads -> done at T+2, next access starts at T+3.
